serial_addsub: RTL

SERIAL_ADDSUB -- requirements
Module: serial_addsub

---
 rtl/serial_addsub_pkg.sv | 13 +
 rtl/addsub_digit.sv | 28 ++
 rtl/serial_addsub.sv | 126 ++++++++++++
 3 files changed

// File: rtl/serial_addsub_pkg.sv
// Shared types and constants for the digit-serial adder/subtractor.
package serial_addsub_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/addsub_digit.sv
// Combinational DIGIT-bit ripple-carry slice; also exposes the carry into its top bit
// so the caller can derive signed overflow on the final digit.
module addsub_digit #(
    parameter int unsigned DIGIT = 1
) (
    input  logic [DIGIT-1:0] a_d,
    input  logic [DIGIT-1:0] b_d,
    input  logic             cin,
    output logic [DIGIT-1:0] s_d,
    output logic             cout_d,
    output logic             c_msb_in
);

    logic c;

    always_comb begin
        c        = cin;
        c_msb_in = cin;
        s_d      = '0;
        for (int i = 0; i < DIGIT; i++) begin
            if (i == DIGIT - 1) c_msb_in = c;
            s_d[i] = a_d[i] ^ b_d[i] ^ c;
            c      = (a_d[i] & b_d[i]) | (c & (a_d[i] ^ b_d[i]));
        end
        cout_d = c;
    end

endmodule

// File: rtl/serial_addsub.sv
// Digit-serial add/subtract with valid/ready handshakes; WIDTH/DIGIT cycles per operation.
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned NSTEPS = WIDTH / DIGIT;
    localparam int unsigned CW     = $clog2(NSTEPS + 1);

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  res_q, res_d;
    logic [WIDTH-1:0]  y_q, y_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              carry_q, carry_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;

    logic [DIGIT-1:0]  slice_s;
    logic              slice_cout;
    logic              slice_cmsb;
    logic [WIDTH-1:0]  slice_ext;
    logic [WIDTH-1:0]  res_next;

    addsub_digit #(
        .DIGIT (DIGIT)
    ) u_digit (
        .a_d      (a_q[DIGIT-1:0]),
        .b_d      (b_q[DIGIT-1:0]),
        .cin      (carry_q),
        .s_d      (slice_s),
        .cout_d   (slice_cout),
        .c_msb_in (slice_cmsb)
    );

    // Sum digits enter from the MSB side, so after NSTEPS shifts the LSB digit sits at bit 0.
    assign slice_ext = WIDTH'(slice_s);
    assign res_next  = (res_q >> DIGIT) | (slice_ext << (WIDTH - DIGIT));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        y_d     = y_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b ^ {WIDTH{sub}};
                    carry_d = (sub == MODE_SUB);
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                res_d   = res_next;
                carry_d = slice_cout;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CW'(NSTEPS - 1)) begin
                    y_d     = res_next;
                    cout_d  = slice_cout;
                    ovf_d   = slice_cmsb ^ slice_cout;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            y_q     <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign y         = y_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule
